// File: rtl/cn_trace_monitor.sv
// Timestamps selector/c/n samples into a small FIFO drained over a valid/ready stream.
// Optional change-only capture filter: define CN_TRACE_FILTER_EN.
module cn_trace_monitor #(
  parameter int W       = 11,
  parameter int STAMP_W = 16,
  parameter int DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 selector,
  input  logic [W-1:0]         c,
  input  logic [W-1:0]         n,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [STAMP_W+2*W:0] trace_data,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = STAMP_W + 1 + 2*W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_state_e;

  fifo_state_e        state_q;
  logic [STAMP_W-1:0] stamp_q;
  logic [AW:0]        wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, count_d;
  logic               first_q, arm_q;
  logic               changed, cap, push, pop, drop, full;
  logic [DW-1:0]      mem [DEPTH];

`ifdef CN_TRACE_FILTER_EN
  logic [W-1:0] last_c_q, last_n_q;

  // Loaded on every capture, dropped ones included, so a retried value is not re-recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_c_q <= '0;
      last_n_q <= '0;
    end else if (cap) begin
      last_c_q <= c;
      last_n_q <= n;
    end
  end

  always_comb begin
    changed = (c != last_c_q) || (n != last_n_q);
  end
`else
  always_comb begin
    changed = 1'b1;
  end
`endif

  always_comb begin
    cap         = arm && (first_q || changed);
    full        = (state_q == ST_FULL);
    trace_valid = (state_q != ST_EMPTY);
    pop         = trace_valid && trace_ready;
    push        = cap && (!full || pop);
    drop        = cap && full && !pop;
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    count_d     = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= ST_EMPTY;
      first_q  <= 1'b1;
      arm_q    <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      stamp_q  <= stamp_q + STAMP_W'(1);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      arm_q    <= arm;
      if (count_d == '0)
        state_q <= ST_EMPTY;
      else if (count_d == DEPTH_C)
        state_q <= ST_FULL;
      else
        state_q <= ST_PARTIAL;
      if (cap)
        first_q <= 1'b0;
      else if (arm_q && !arm)
        first_q <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Storage is deliberately not reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q[AW-1:0]] <= {stamp_q, selector, c, n};
  end

  always_comb begin
    trace_data = mem[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: tb/tb_cn_trace_monitor.sv
// Scoreboard bench for cn_trace_monitor: a 16-bit-stamp instance for FIFO behaviour and a 4-bit-stamp instance for wrap.
module tb_cn_trace_monitor;
  localparam int W     = 11;
  localparam int SW    = 16;
  localparam int SW2   = 4;
  localparam int DEPTH = 8;
  localparam int DW    = SW + 1 + 2*W;
  localparam int DW2   = SW2 + 1 + 2*W;
`ifdef CN_TRACE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic selector = 1'b0;
  logic [W-1:0] c = '0;
  logic [W-1:0] n = '0;
  logic trace_ready = 1'b0;
  logic trace_valid, overflow;
  logic [DW-1:0] trace_data;
  logic [7:0] drop_cnt;

  logic arm2 = 1'b0;
  logic sel2 = 1'b0;
  logic [W-1:0] c2 = '0;
  logic [W-1:0] n2 = '0;
  logic valid2, overflow2;
  logic [DW2-1:0] data2;
  logic [7:0] drop2;

  logic [SW-1:0] tcyc;
  logic [DW-1:0] q[$];
  logic [DW2-1:0] q2[$];
  logic [DW2-1:0] e2;
  int exp_drop = 0;
  logic exp_ovf = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cn_trace_monitor #(.W(W), .STAMP_W(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .selector(selector), .c(c), .n(n),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  cn_trace_monitor #(.W(W), .STAMP_W(SW2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .arm(arm2), .selector(sel2), .c(c2), .n(n2),
    .trace_valid(valid2), .trace_ready(1'b1), .trace_data(data2),
    .overflow(overflow2), .drop_cnt(drop2)
  );

  // Bench cycle counter: the stamp a capture at the next edge must carry.
  always @(posedge clk or posedge rst) begin
    if (rst) tcyc <= '0;
    else     tcyc <= tcyc + 16'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; expc is the hand-decided capture for this cycle.
  task automatic step(input logic a, input logic s, input logic [W-1:0] cv,
                      input logic [W-1:0] nv, input logic rdy, input logic expc);
    logic will_push, will_drop;
    logic [DW-1:0] e;
    arm = a; selector = s; c = cv; n = nv; trace_ready = rdy;
    e = {tcyc, s, cv, nv};
    will_push = expc && (q.size() < DEPTH || (rdy && q.size() != 0));
    will_drop = expc && !will_push;
    @(posedge clk);
    #1;
    if (will_push) q.push_back(e);
    if (will_drop) begin
      exp_ovf = 1'b1;
      if (exp_drop < 255) exp_drop++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", trace_valid, q.size() != 0);
      chk("overflow", overflow, exp_ovf);
      chk("drop_cnt", drop_cnt, exp_drop);
      if (trace_valid && q.size() != 0) begin
        chk(trace_ready ? "pop_data" : "head_data", trace_data, q[0]);
        if (trace_ready) void'(q.pop_front());
      end
      chk("valid2", valid2, q2.size() != 0);
      chk("drop_cnt2", drop2, 0);
      if (valid2 && q2.size() != 0) begin
        e2 = q2.pop_front();
        chk("data2", data2, e2);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Filter: constant c/n with toggling selector, then a change in c.
    for (int i = 0; i < 10; i++) step(1'b1, i[0], 11'd5, 11'd7, 1'b1, FILT ? (i == 0) : 1'b1);
    step(1'b1, 1'b0, 11'd6, 11'd7, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Overflow: 12 captures into a stalled 8-deep FIFO, then drain.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, W'(i + 1), 11'd3, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, W'(100 + i), 11'd3, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, W'(200 + i), 11'd3, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Re-arm with unchanged c/n.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 11'd4, 11'd4, 1'b1, FILT ? (i == 0) : 1'b1);
    step(1'b0, 1'b0, 11'd4, 11'd4, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 11'd4, 11'd4, 1'b1, FILT ? (i == 0) : 1'b1);
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, W'(300 + i), 11'd5, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Reset mid-stream with 3 entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(i + 1), 11'd0, 1'b0, 1'b1);
    arm = 1'b0;
    rst = 1'b1;
    q.delete();
    exp_drop = 0;
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b1, 11'd9, 11'd9, 1'b0, 1'b1);
    arm = 1'b0;
    #3;
    chk("rst_valid", trace_valid, 1);
    chk("rst_stamp", trace_data[DW-1 -: SW], 0);
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Stamp wrap on the 4-bit instance.
    for (int i = 0; i < 20; i++) begin
      logic [DW2-1:0] ev;
      arm2 = 1'b1;
      c2 = W'(i + 1);
      ev = {tcyc[SW2-1:0], sel2, c2, n2};
      @(posedge clk);
      #1;
      q2.push_back(ev);
    end
    arm2 = 1'b0;
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    chk("main_drained", q.size(), 0);
    chk("wrap_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cn_trace_monitor.md
# cn_trace_monitor

Observation-side companion to the arithmetic case harness. It samples the DUT's `selector` input and `c`/`n` outputs every clock and timestamps each qualifying sample. Samples are buffered in a small FIFO and drained over a valid/ready stream, so property-mining tooling can read the execution trace. It is the consumer end of the stimulus path: the bench writes `selector`, the DUT produces `c`/`n`, and this block reads and records all three.

## Interface
Parameters:
- `W`, 11, width of `c` and `n`
- `STAMP_W`, 16, width of the cycle timestamp
- `DEPTH`, 8, FIFO entries; must be a power of two, at least 2

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `arm`  in  1  recording enable; samples are captured only while high
- `selector`  in  1  DUT selector input, as driven by the bench
- `c`  in  W  DUT output c
- `n`  in  W  DUT output n
- `trace_valid`  out  1  FIFO head holds an entry
- `trace_ready`  in  1  consumer accepts the head entry
- `trace_data`  out  STAMP_W+1+2W  bit fields from MSB to LSB: {stamp, selector, c, n}
- `overflow`  out  1  sticky; set when an entry was dropped
- `drop_cnt`  out  8  count of dropped entries; saturates at 255

## Operation
- Stamp counter:
  - free-running; set to 0 by reset, then increments every cycle.
  - wraps from 2^STAMP_W-1 to 0.
  - a captured entry carries the stamp value of its capture cycle.
- Capture condition `cap`, evaluated each cycle:
  - requires `arm`=1.
  - with the filter compiled in (see Configuration), also requires `first` or (`c`,`n`) different from the last captured pair.
- `first`:
  - set by reset.
  - set on every falling edge of `arm` (the cycle after `arm` deasserts).
  - cleared when an entry is captured.
- Last-captured pair register: loaded with (`c`,`n`) on every capture, including a capture that is dropped because the FIFO is full.
- FIFO:
  - `rd_ptr`, `wr_ptr` of log2(DEPTH)+1 bits; count = wr_ptr - rd_ptr.
  - full when count equals DEPTH; empty when count is 0.
- Push: `cap` and (not full, or pop this cycle).
- Pop: `trace_valid` and `trace_ready`.
- Drop: `cap` and full and no pop this cycle.
  - the entry is discarded and `overflow` is set.
  - `drop_cnt` increments, saturating at 255.
- `trace_data` is mem[rd_ptr]. It is meaningful only while `trace_valid` is high and must hold stable while `trace_valid`=1 and `trace_ready`=0.
- States, implied by count: EMPTY (count 0), PARTIAL, FULL (count DEPTH).
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Reset: returns every element to its reset state at any time, including mid-drain; FIFO contents are not cleared, only the pointers.

## Timing
- Reset values:
  - `trace_valid`=0, `overflow`=0, `drop_cnt`=0.
  - stamp=0, pointers=0, `first`=1.
  - `trace_data` has no reset value; it is don't-care while `trace_valid`=0.
- Capture latency: a sample captured at edge k appears with `trace_valid`=1 after edge k (one cycle).
- No bypass: an empty FIFO cannot present and pop the same cycle's sample.
- Full plus simultaneous pop: the push is accepted and count stays at DEPTH.
- `trace_ready` has no effect while `trace_valid`=0.
- `trace_valid` does not depend combinationally on `trace_ready`.
- `arm` deasserted: no captures; draining continues normally.

## Configuration
- `CN_TRACE_FILTER_EN` defined:
  - change-only capture: an entry is recorded when armed and `first`, or when `c` or `n` differs from the last captured pair.
  - `selector` changes alone do not trigger a capture.
- Not defined:
  - every armed cycle is captured.
  - the last-captured pair register and its compare logic are not built; `first` still tracks as specified.

## Test plan
- Reset: hold `rst`=1 mid-stream with 3 entries queued -> after release, `trace_valid`=0, `drop_cnt`=0, first capture has stamp 0 or greater counted from reset.
- Filter on, arm=1, c/n constant at 5/7 for 10 cycles then c=6 -> exactly 2 entries, {stamp0,sel,5,7} then {stamp0+10,sel,6,7}.
- Filter off, arm=1, `trace_ready`=0 for 12 cycles, DEPTH=8 -> 8 entries with consecutive stamps, `overflow`=1, `drop_cnt`=4, later draining yields the first 8 in order.
- Full FIFO with `trace_ready`=1 and capture each cycle -> count stays 8, no drops, stamps contiguous on output.
- Stamp wrap with STAMP_W=4, filter off -> stamps 14,15,0,1 in successive entries.
- arm toggles 1->0->1 with c/n unchanged, filter on -> one new entry on re-arm (`first` behaviour).
